unpack_s3: RTL and testbench



---
 rtl/ntru_s3_pkg.sv | 19 +
 rtl/div3_u8.sv | 19 +
 rtl/unpack_s3.sv | 104 ++++++++++
 tb/tb_unpack_s3.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntru_s3_pkg.sv
// Shared definitions for S3 polynomial byte packing/unpacking logic.
package ntru_s3_pkg;

    localparam logic [1:0] TRIT_0 = 2'b00;
    localparam logic [1:0] TRIT_1 = 2'b01;
    localparam logic [1:0] TRIT_2 = 2'b10;

    localparam int N_BYTES_DEFAULT = 140;

    // Largest byte that encodes five valid base-3 digits (3^5 - 1).
    localparam logic [7:0] MAX_PACKED_BYTE = 8'd242;

    typedef enum logic [1:0] {
        IDLE,
        DIGIT,
        DONE
    } state_t;

endpackage

// File: rtl/div3_u8.sv
// Combinational divide-by-3 of an unsigned byte; remainder comes out trit-encoded.
module div3_u8 (
    input  logic [7:0] b,
    output logic [6:0] q,
    output logic [1:0] r
);

    logic [7:0] quot;
    logic [7:0] rem;

    // Quotient and remainder of the constant division.
    always_comb begin
        quot = b / 8'd3;
        rem  = b % 8'd3;
        q    = quot[6:0];
        r    = rem[1:0];
    end

endmodule

// File: rtl/unpack_s3.sv
// Sequential S3 unpacker: one base-3 digit per clock, five trits per packed byte.
//
// state | meaning
// IDLE  | waiting for start after reset
// DIGIT | extracting one trit per cycle
// DONE  | result valid on out, waiting for a restart
module unpack_s3
    import ntru_s3_pkg::*;
#(
    parameter int N_BYTES = N_BYTES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*N_BYTES-1:0]    a,
    output logic [10*N_BYTES-1:0]   out,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int CW = $clog2(N_BYTES + 1);
    localparam int OW = 10 * N_BYTES;
    localparam int AW = 8 * N_BYTES;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   byte_sr;
    logic [7:0]      work;
    logic [2:0]      k;
    logic [CW-1:0]   byte_cnt;
    logic [6:0]      q;
    logic [1:0]      r;
    logic            start_ok;
    logic            last_digit;
    logic            last_byte;

    div3_u8 u_div3 (
        .b (work),
        .q (q),
        .r (r)
    );

    assign start_ok   = start && (state != DIGIT);
    assign last_digit = (k == 3'd4);
    assign last_byte  = (byte_cnt == CW'(N_BYTES - 1));
    assign busy       = (state == DIGIT);
    assign done       = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is honoured only outside DIGIT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = DIGIT;
            end
            DIGIT: begin
                if (last_digit && last_byte) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on start, then shift one trit into the top of out each DIGIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out      <= '0;
            byte_sr  <= '0;
            work     <= '0;
            k        <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
        end else if (start_ok) begin
            byte_sr  <= a;
            work     <= a[7:0];
            k        <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
        end else if (state == DIGIT) begin
            out <= {r, out[OW-1:2]};
            if (last_digit) begin
                // After four divisions a valid byte leaves 0..2; 3 means the byte exceeded 242.
                if (work > 8'd2) err <= 1'b1;
                byte_sr  <= byte_sr >> 8;
                work     <= byte_sr[15:8];
                k        <= '0;
                byte_cnt <= byte_cnt + 1'b1;
            end else begin
                work <= {1'b0, q};
                k    <= k + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_unpack_s3.sv
// Directed self-checking bench for unpack_s3.
module tb_unpack_s3;

    localparam int NB = 140;
    localparam int NT = 5 * NB;
    localparam int OW = 10 * NB;

    logic            clk;
    logic            rst;
    logic            start;
    logic [8*NB-1:0] a;
    logic [OW-1:0]   out;
    logic            busy;
    logic            done;
    logic            err;

    int checks;
    int failures;

    unpack_s3 #(.N_BYTES(NB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .out   (out),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      trits [NT];
    logic [8*NB-1:0] packed_v;
    logic [OW-1:0]   exp_out;

    // Reference packer: byte i = sum_k trit[5i+k] * 3^k.
    task automatic pack_s3();
        int v;
        packed_v = '0;
        exp_out  = '0;
        for (int i = 0; i < NB; i++) begin
            v = 0;
            for (int kk = 4; kk >= 0; kk--) v = v * 3 + int'(trits[5*i+kk]);
            packed_v[8*i +: 8] = v[7:0];
        end
        for (int j = 0; j < NT; j++) exp_out[2*j +: 2] = trits[j];
    endtask

    task automatic random_trits();
        for (int j = 0; j < NT; j++) trits[j] = 2'($urandom_range(0, 2));
        pack_s3();
    endtask

    // Pulse start so the following posedge is edge 0, then count edges until done.
    task automatic run_decode(input logic [8*NB-1:0] data, output int lat);
        @(negedge clk);
        a     = data;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 800) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        #12;
        checks++;
        if (out !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b err=%b out_nonzero=%b required all zero",
                     busy, done, err, |out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        int lat;
        run_decode('0, lat);
        checks++;
        if (lat !== NT) begin
            failures++;
            $display("FAIL zero_latency: got %0d required %0d", lat, NT);
        end
        checks++;
        if (out !== '0 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_result: out_nonzero=%b err=%b busy=%b required 0 0 0", |out, err, busy);
        end
    endtask

    task automatic test_all_242();
        int lat;
        logic [8*NB-1:0] d;
        logic [OW-1:0]   e;
        for (int i = 0; i < NB; i++) d[8*i +: 8] = 8'hF2;
        for (int j = 0; j < NT; j++) e[2*j +: 2] = 2'b10;
        run_decode(d, lat);
        checks++;
        if (out !== e || err !== 1'b0) begin
            failures++;
            $display("FAIL all_242: out_ok=%b err=%b required out all 2'b10 err=0", out === e, err);
        end
    endtask

    task automatic test_ends();
        int lat;
        logic [8*NB-1:0] d;
        logic [OW-1:0]   e;
        d = '0;
        d[7:0]            = 8'h01;
        d[8*139 +: 8]     = 8'h51;
        e = '0;
        e[1:0]            = 2'b01;
        e[OW-1:OW-2]      = 2'b01;
        run_decode(d, lat);
        checks++;
        if (out[1:0] !== 2'b01) begin
            failures++;
            $display("FAIL ends_trit0: got %b required 01", out[1:0]);
        end
        checks++;
        if (out[OW-1:OW-2] !== 2'b01) begin
            failures++;
            $display("FAIL ends_trit699: got %b required 01", out[OW-1:OW-2]);
        end
        checks++;
        if (out !== e) begin
            failures++;
            $display("FAIL ends_rest: other trits not all zero");
        end
    endtask

    // Byte 5 = 0xFF: 255 = 0 + 1*3 + 1*9 + 0*27 + 3*81, fifth digit 3 becomes trit 0.
    task automatic test_invalid();
        int cyc;
        logic [8*NB-1:0] d;
        logic [OW-1:0]   e;
        d = '0;
        d[8*5 +: 8] = 8'hFF;
        e = '0;
        e[2*26 +: 2] = 2'b01;
        e[2*27 +: 2] = 2'b01;
        @(negedge clk);
        a     = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 800) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 29) begin
                checks++;
                if (err !== 1'b0) begin
                    failures++;
                    $display("FAIL err_before: edge 29 err=%b required 0", err);
                end
            end
            if (cyc == 30) begin
                checks++;
                if (err !== 1'b1) begin
                    failures++;
                    $display("FAIL err_rise: edge 30 err=%b required 1", err);
                end
            end
        end
        checks++;
        if (out !== e || err !== 1'b1 || cyc !== NT) begin
            failures++;
            $display("FAIL invalid_result: out_ok=%b err=%b cycles=%0d required 1 1 %0d",
                     out === e, err, cyc, NT);
        end
    endtask

    // Restart from DONE clears done/err on the start edge; mid-run start is ignored.
    task automatic test_back_to_back();
        int cyc;
        random_trits();
        @(negedge clk);
        a     = packed_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~packed_v;
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart: done=%b err=%b busy=%b required 0 0 1", done, err, busy);
        end
        cyc = 0;
        while (!done && cyc < 800) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 100) start = 1'b1;
            if (cyc == 101) start = 1'b0;
        end
        checks++;
        if (cyc !== NT) begin
            failures++;
            $display("FAIL ignore_start_latency: got %0d required %0d", cyc, NT);
        end
        checks++;
        if (out !== exp_out || err !== 1'b0) begin
            failures++;
            $display("FAIL random_decode: out_ok=%b err=%b required 1 0", out === exp_out, err);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        int lat;
        random_trits();
        @(negedge clk);
        a     = packed_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (cyc = 0; cyc < 300; cyc++) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b err=%b out_nonzero=%b required all zero",
                     busy, done, err, |out);
        end
        @(negedge clk);
        rst = 1'b0;
        random_trits();
        run_decode(packed_v, lat);
        checks++;
        if (lat !== NT || out !== exp_out) begin
            failures++;
            $display("FAIL after_reset: latency=%0d out_ok=%b required %0d 1", lat, out === exp_out, NT);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero();
        test_all_242();
        test_ends();
        test_invalid();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
